// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and SDA mux codes for the I2C slave control FSM
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE          = 4'd0,
    ST_ADDR_RX       = 4'd1,
    ST_ADDR_CHK      = 4'd2,
    ST_ADDR_ACK_WAIT = 4'd3,
    ST_ADDR_ACK      = 4'd4,
    ST_WR_RX         = 4'd5,
    ST_WR_STORE      = 4'd6,
    ST_WR_ACK_WAIT   = 4'd7,
    ST_WR_ACK        = 4'd8,
    ST_WR_NACK_WAIT  = 4'd9,
    ST_WR_NACK       = 4'd10,
    ST_RD_LOAD       = 4'd11,
    ST_RD_TX         = 4'd12,
    ST_RD_ACK_CHK    = 4'd13,
    ST_RD_ACKED      = 4'd14,
    ST_WAIT_STOP     = 4'd15
  } state_t;

  localparam logic [1:0] SDA_RELEASE = 2'b00;
  localparam logic [1:0] SDA_ACK     = 2'b01;
  localparam logic [1:0] SDA_NACK    = 2'b10;
  localparam logic [1:0] SDA_DATA    = 2'b11;

endpackage

// File: rtl/i2c_slave_ctrl.sv
// rtl/i2c_slave_ctrl.sv - I2C slave control FSM sequencing shift register, SDA mux and RX/TX FIFOs
module i2c_slave_ctrl
  import i2c_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start_found,
  input  logic       stop_found,
  input  logic       byte_received,
  input  logic       ack_prep,
  input  logic       check_ack,
  input  logic       ack_done,
  input  logic       address_match,
  input  logic       rw_mode,
  input  logic       sda_in,
  input  logic       rx_fifo_full,
  input  logic       tx_fifo_empty,
  output logic       rx_enable,
  output logic       tx_enable,
  output logic       load_data,
  output logic       read_enable,
  output logic       write_enable,
  output logic [1:0] sda_mode,
  output logic       tx_underrun,
  output logic       busy
);

  state_t state;
  state_t nxt;
  logic   rw_q;

  // Stop beats start, start beats every state-local transition.
  always_comb begin
    nxt = state;
    if (stop_found) begin
      nxt = ST_IDLE;
    end else if (start_found) begin
      nxt = ST_ADDR_RX;
    end else begin
      case (state)
        ST_IDLE:          nxt = ST_IDLE;
        ST_ADDR_RX:       if (byte_received) nxt = ST_ADDR_CHK;
        ST_ADDR_CHK:      nxt = address_match ? ST_ADDR_ACK_WAIT : ST_WAIT_STOP;
        ST_ADDR_ACK_WAIT: if (ack_prep) nxt = ST_ADDR_ACK;
        ST_ADDR_ACK:      if (ack_done) nxt = rw_q ? ST_RD_LOAD : ST_WR_RX;
        ST_WR_RX:         if (byte_received) nxt = rx_fifo_full ? ST_WR_NACK_WAIT : ST_WR_STORE;
        ST_WR_STORE:      nxt = ST_WR_ACK_WAIT;
        ST_WR_ACK_WAIT:   if (ack_prep) nxt = ST_WR_ACK;
        ST_WR_ACK:        if (ack_done) nxt = ST_WR_RX;
        ST_WR_NACK_WAIT:  if (ack_prep) nxt = ST_WR_NACK;
        ST_WR_NACK:       if (ack_done) nxt = ST_WAIT_STOP;
        ST_RD_LOAD:       nxt = ST_RD_TX;
        ST_RD_TX:         if (ack_prep) nxt = ST_RD_ACK_CHK;
        ST_RD_ACK_CHK:    if (check_ack) nxt = sda_in ? ST_WAIT_STOP : ST_RD_ACKED;
        ST_RD_ACKED:      if (ack_done) nxt = ST_RD_LOAD;
        ST_WAIT_STOP:     nxt = ST_WAIT_STOP;
        default:          nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      rw_q         <= 1'b0;
      rx_enable    <= 1'b0;
      tx_enable    <= 1'b0;
      load_data    <= 1'b0;
      read_enable  <= 1'b0;
      write_enable <= 1'b0;
      tx_underrun  <= 1'b0;
      busy         <= 1'b0;
      sda_mode     <= SDA_RELEASE;
    end else begin
      state <= nxt;
      if (state == ST_ADDR_CHK) rw_q <= rw_mode;
      rx_enable    <= (nxt == ST_ADDR_RX) || (nxt == ST_WR_RX);
      tx_enable    <= (nxt == ST_RD_TX);
      load_data    <= (nxt == ST_RD_LOAD);
      read_enable  <= (nxt == ST_RD_LOAD) && !tx_fifo_empty;
      tx_underrun  <= (nxt == ST_RD_LOAD) && tx_fifo_empty;
      write_enable <= (nxt == ST_WR_STORE);
      busy         <= (nxt != ST_IDLE);
      case (nxt)
        ST_ADDR_ACK, ST_WR_ACK: sda_mode <= SDA_ACK;
        ST_WR_NACK:             sda_mode <= SDA_NACK;
        ST_RD_TX:               sda_mode <= SDA_DATA;
        default:                sda_mode <= SDA_RELEASE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// tb/tb_i2c_slave_ctrl.sv - table-driven self-checking bench for i2c_slave_ctrl
module tb_i2c_slave_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_found, stop_found, byte_received, ack_prep, check_ack, ack_done;
  logic       address_match, rw_mode, sda_in, rx_fifo_full, tx_fifo_empty;
  logic       rx_enable, tx_enable, load_data, read_enable, write_enable, tx_underrun, busy;
  logic [1:0] sda_mode;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  i2c_slave_ctrl dut (
    .clk(clk), .rst(rst),
    .start_found(start_found), .stop_found(stop_found), .byte_received(byte_received),
    .ack_prep(ack_prep), .check_ack(check_ack), .ack_done(ack_done),
    .address_match(address_match), .rw_mode(rw_mode), .sda_in(sda_in),
    .rx_fifo_full(rx_fifo_full), .tx_fifo_empty(tx_fifo_empty),
    .rx_enable(rx_enable), .tx_enable(tx_enable), .load_data(load_data),
    .read_enable(read_enable), .write_enable(write_enable), .sda_mode(sda_mode),
    .tx_underrun(tx_underrun), .busy(busy)
  );

  // Input bits: {start, stop, byte_rx, ack_prep, check_ack, ack_done, addr_match, rw, sda_in, rx_full, tx_empty}
  localparam logic [10:0] NO = 11'd0;
  localparam logic [10:0] ST = 11'b100_0000_0000;
  localparam logic [10:0] SP = 11'b010_0000_0000;
  localparam logic [10:0] BR = 11'b001_0000_0000;
  localparam logic [10:0] PR = 11'b000_1000_0000;
  localparam logic [10:0] CK = 11'b000_0100_0000;
  localparam logic [10:0] DN = 11'b000_0010_0000;
  localparam logic [10:0] AM = 11'b000_0001_0000;
  localparam logic [10:0] RW = 11'b000_0000_1000;
  localparam logic [10:0] SD = 11'b000_0000_0100;
  localparam logic [10:0] FL = 11'b000_0000_0010;
  localparam logic [10:0] EM = 11'b000_0000_0001;

  // Output bits: {busy, rx_en, tx_en, load, rd_en, wr_en, underrun, sda_mode[1:0]}
  localparam logic [8:0] O0 = 9'd0;
  localparam logic [8:0] B  = 9'b1_0000_0000;
  localparam logic [8:0] RX = 9'b0_1000_0000;
  localparam logic [8:0] TX = 9'b0_0100_0000;
  localparam logic [8:0] LD = 9'b0_0010_0000;
  localparam logic [8:0] RE = 9'b0_0001_0000;
  localparam logic [8:0] WE = 9'b0_0000_1000;
  localparam logic [8:0] UN = 9'b0_0000_0100;
  localparam logic [8:0] MA = 9'b0_0000_0001;
  localparam logic [8:0] MN = 9'b0_0000_0010;
  localparam logic [8:0] MD = 9'b0_0000_0011;

  typedef struct packed {
    logic [10:0] in;
    logic [8:0]  exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic [10:0] in, logic [8:0] exp);
    vec_t r;
    r.in  = in;
    r.exp = exp;
    return r;
  endfunction

  function automatic logic [8:0] obs();
    return {busy, rx_enable, tx_enable, load_data, read_enable, write_enable, tx_underrun, sda_mode};
  endfunction

  task automatic drive(input logic [10:0] in);
    {start_found, stop_found, byte_received, ack_prep, check_ack, ack_done,
     address_match, rw_mode, sda_in, rx_fifo_full, tx_fifo_empty} = in;
  endtask

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b (busy,rx,tx,ld,rd,wr,un,mode)", name, got, exp);
    end
  endtask

  task automatic step(input string name, input logic [10:0] in, input logic [8:0] exp);
    drive(in);
    @(posedge clk);
    #1;
    check(name, obs(), exp);
  endtask

  initial begin
    rst = 1'b1;
    drive(NO);
    repeat (2) @(posedge clk);
    #1;
    check("reset", obs(), O0);
    rst = 1'b0;

    // Address write match, byte stored, second byte refused on full FIFO
    tbl.push_back(v(ST,      B|RX));
    tbl.push_back(v(BR,      B));
    tbl.push_back(v(AM,      B));
    tbl.push_back(v(NO,      B));
    tbl.push_back(v(PR,      B|MA));
    tbl.push_back(v(NO,      B|MA));
    tbl.push_back(v(DN,      B|RX));
    tbl.push_back(v(BR,      B|WE));
    tbl.push_back(v(NO,      B));
    tbl.push_back(v(PR,      B|MA));
    tbl.push_back(v(DN,      B|RX));
    tbl.push_back(v(BR|FL,   B));
    tbl.push_back(v(PR,      B|MN));
    tbl.push_back(v(NO,      B|MN));
    tbl.push_back(v(DN,      B));
    tbl.push_back(v(BR|PR,   B));
    tbl.push_back(v(SP,      O0));
    tbl.push_back(v(NO,      O0));
    // Address mismatch: everything ignored until stop
    tbl.push_back(v(ST,      B|RX));
    tbl.push_back(v(BR|AM,   B));
    tbl.push_back(v(NO,      B));
    tbl.push_back(v(PR,      B));
    tbl.push_back(v(DN,      B));
    tbl.push_back(v(BR|CK,   B));
    tbl.push_back(v(SP,      O0));
    // Read, master ACKs first byte then NACKs second
    tbl.push_back(v(ST,      B|RX));
    tbl.push_back(v(BR,      B));
    tbl.push_back(v(AM|RW,   B));
    tbl.push_back(v(PR,      B|MA));
    tbl.push_back(v(DN,      B|LD|RE));
    tbl.push_back(v(NO,      B|TX|MD));
    tbl.push_back(v(BR,      B|TX|MD));
    tbl.push_back(v(PR,      B));
    tbl.push_back(v(CK,      B));
    tbl.push_back(v(DN,      B|LD|RE));
    tbl.push_back(v(NO,      B|TX|MD));
    tbl.push_back(v(PR,      B));
    tbl.push_back(v(CK|SD,   B));
    tbl.push_back(v(DN,      B));
    tbl.push_back(v(NO,      B));
    tbl.push_back(v(SP,      O0));
    // Read with empty TX FIFO: underrun pulse
    tbl.push_back(v(ST,      B|RX));
    tbl.push_back(v(BR,      B));
    tbl.push_back(v(AM|RW,   B));
    tbl.push_back(v(PR,      B|MA));
    tbl.push_back(v(DN|EM,   B|LD|UN));
    tbl.push_back(v(EM,      B|TX|MD));
    tbl.push_back(v(EM,      B|TX|MD));
    tbl.push_back(v(ST|SP,   O0));
    // Repeated start during a write byte, then start+stop together
    tbl.push_back(v(ST,      B|RX));
    tbl.push_back(v(BR,      B));
    tbl.push_back(v(AM,      B));
    tbl.push_back(v(PR,      B|MA));
    tbl.push_back(v(DN,      B|RX));
    tbl.push_back(v(ST|BR,   B|RX));
    tbl.push_back(v(BR,      B));
    tbl.push_back(v(NO,      B));
    tbl.push_back(v(ST|SP,   O0));
    tbl.push_back(v(NO,      O0));

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("row%0d", i), tbl[i].in, tbl[i].exp);
    end

    // Reset asserted mid RD_TX releases everything on the next edge
    step("rd_addr_start", ST, B|RX);
    step("rd_addr_byte", BR, B);
    step("rd_addr_chk", AM|RW, B);
    step("rd_addr_ack", PR, B|MA);
    step("rd_load", DN, B|LD|RE);
    step("rd_tx", NO, B|TX|MD);
    rst = 1'b1;
    step("rst_mid_tx", NO, O0);
    rst = 1'b0;
    step("post_rst_idle", BR|PR|DN, O0);

    // Latched rw must be cleared by reset: a new write address goes to WR_RX
    step("wr_after_rst_start", ST, B|RX);
    step("wr_after_rst_byte", BR, B);
    step("wr_after_rst_chk", AM, B);
    step("wr_after_rst_ack", PR, B|MA);
    step("wr_after_rst_done", DN, B|RX);
    step("wr_after_rst_stop", SP, O0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
